ddr_port_arbiter: RTL

- Shares the single MIG command/data port between the four DDR movers: weight fetch, bias fetch, data fetch and data write-back.
- Arbitrates round-robin and issues one command at a time.
- Holds the grant, and therefore the data-path select, until every data beat of that command has transferred.
- Sits between the fetch/write controllers and the MIG user interface. Its grant index drives the `switch` and `mig_type` routing.

---
 rtl/ddr_port_arbiter_if.sv | 57 +++++
 rtl/ddr_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - requester, MIG command and beat signals of the DDR port arbiter
interface ddr_port_arbiter_if #(
  parameter int N_REQ        = 4,
  parameter int DDR_ADDR_LEN = 32,
  parameter int LEN_W        = 8
);
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*DDR_ADDR_LEN-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]        req_len;
  logic [N_REQ-1:0]              req_ready;

  logic                          mig_cmd_valid;
  logic                          mig_cmd_ready;
  logic                          mig_cmd_wr;
  logic [DDR_ADDR_LEN-1:0]       mig_addr;
  logic [LEN_W-1:0]              mig_len;

  logic                          beat;
  logic                          grant_vld;
  logic [1:0]                    grant_idx;
  logic                          xfer_done;
  logic                          err_extra_beat;

  modport master (
    input  req_valid,
    input  req_addr,
    input  req_len,
    input  mig_cmd_ready,
    input  beat,
    output req_ready,
    output mig_cmd_valid,
    output mig_cmd_wr,
    output mig_addr,
    output mig_len,
    output grant_vld,
    output grant_idx,
    output xfer_done,
    output err_extra_beat
  );

  modport slave (
    output req_valid,
    output req_addr,
    output req_len,
    output mig_cmd_ready,
    output beat,
    input  req_ready,
    input  mig_cmd_valid,
    input  mig_cmd_wr,
    input  mig_addr,
    input  mig_len,
    input  grant_vld,
    input  grant_idx,
    input  xfer_done,
    input  err_extra_beat
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - round-robin owner of the single MIG command/data port
module ddr_port_arbiter #(
  parameter int               N_REQ        = 4,
  parameter int               DDR_ADDR_LEN = 32,
  parameter int               LEN_W        = 8,
  parameter logic [N_REQ-1:0] WR_MASK      = 4'b1000
) (
  input  logic               clk,
  input  logic               rst,
  ddr_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              rr_q, rr_d;
  logic [LEN_W:0]          cnt_q, cnt_d;
  logic [LEN_W:0]          cnt_now;
  logic [LEN_W:0]          len_plus1;
  logic                    cmd_vld_q, cmd_vld_d;
  logic                    wr_q, wr_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    gvld_q, gvld_d;
  logic [1:0]              gidx_q, gidx_d;
  logic [N_REQ-1:0]        rdy_q, rdy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [1:0]              pick_idx;
  logic                    pick_vld;
  logic [2:0]              cand_sum;
  logic [1:0]              cand;
  logic [1:0]              gidx_inc;
  logic                    beats_full;

  // Scan from rr_q upward; iterating high-to-low lets the nearest hit win.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_q} + 3'(k);
      cand     = (cand_sum >= 3'(N_REQ)) ? 2'(cand_sum - 3'(N_REQ)) : cand_sum[1:0];
      if (bus.req_valid[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign len_plus1  = {1'b0, len_q} + 1'b1;
  assign beats_full = (cnt_q == len_plus1);
  assign gidx_inc   = (gidx_q == 2'(N_REQ - 1)) ? 2'd0 : gidx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    cnt_now   = cnt_q;
    cmd_vld_d = cmd_vld_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    gvld_d    = gvld_q;
    gidx_d    = gidx_q;
    rdy_d     = '0;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (bus.beat) begin
          err_d = 1'b1;
        end
        // The done cycle is skipped so a requester whose req_ready is still
        // visible this cycle cannot be re-granted on its stale req_valid.
        if (pick_vld && !done_q) begin
          addr_d    = bus.req_addr[pick_idx*DDR_ADDR_LEN +: DDR_ADDR_LEN];
          len_d     = bus.req_len[pick_idx*LEN_W +: LEN_W];
          wr_d      = WR_MASK[pick_idx];
          gidx_d    = pick_idx;
          gvld_d    = 1'b1;
          cnt_d     = '0;
          cmd_vld_d = 1'b1;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.beat) begin
          if (beats_full) begin
            err_d = 1'b1;
          end else begin
            cnt_now = cnt_q + 1'b1;
          end
        end
        cnt_d = cnt_now;
        if (bus.mig_cmd_ready) begin
          cmd_vld_d     = 1'b0;
          rdy_d[gidx_q] = 1'b1;
          if (cnt_now == len_plus1) begin
            done_d  = 1'b1;
            gvld_d  = 1'b0;
            rr_d    = gidx_inc;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (bus.beat) begin
          if (cnt_q == {1'b0, len_q}) begin
            done_d  = 1'b1;
            gvld_d  = 1'b0;
            rr_d    = gidx_inc;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      cnt_q     <= '0;
      cmd_vld_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      gvld_q    <= 1'b0;
      gidx_q    <= '0;
      rdy_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      cmd_vld_q <= cmd_vld_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      gvld_q    <= gvld_d;
      gidx_q    <= gidx_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready      = rdy_q;
  assign bus.mig_cmd_valid  = cmd_vld_q;
  assign bus.mig_cmd_wr     = wr_q;
  assign bus.mig_addr       = addr_q;
  assign bus.mig_len        = len_q;
  assign bus.grant_vld      = gvld_q;
  assign bus.grant_idx      = gidx_q;
  assign bus.xfer_done      = done_q;
  assign bus.err_extra_beat = err_q;

endmodule
